// File: rtl/tc_div_31s_16u_17s.sv
// Sequential restoring divider: 31-bit signed dividend / 16-bit unsigned divisor,
// producing a 17-bit signed saturated quotient (truncated toward zero) and remainder.
// One division in flight, valid/ready on both sides, 31 cycles per division.
// Optional feature macro: TC_DIV_REMAINDER_EN (remainder register and port value);
// when undefined the remainder port is tied to zero.
module tc_div_31s_16u_17s #(
  parameter int unsigned DIVIDEND_WIDTH = 31,
  parameter int unsigned DIVISOR_WIDTH  = 16,
  parameter int unsigned QUOTIENT_WIDTH = 17
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [QUOTIENT_WIDTH-1:0] remainder,
  output logic                      overflow,
  output logic                      div_by_zero
);

  localparam int unsigned CntW = $clog2(DIVIDEND_WIDTH);
  localparam int unsigned RemW = DIVISOR_WIDTH + 1;
  localparam int unsigned PadW = DIVIDEND_WIDTH + 1 - QUOTIENT_WIDTH;

  // Saturation bounds, both at output width and at the wide signed quotient width
  localparam logic [QUOTIENT_WIDTH-1:0] QMaxQ = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH-1:0] QMinQ = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};
  localparam logic signed [DIVIDEND_WIDTH:0] QMaxW = $signed({{PadW{1'b0}}, QMaxQ});
  localparam logic signed [DIVIDEND_WIDTH:0] QMinW = $signed({{PadW{1'b1}}, QMinQ});

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                      state_q, state_d;
  logic                        sign_q, sign_d;
  logic [DIVIDEND_WIDTH-1:0]   mag_q, mag_d;
  logic [DIVISOR_WIDTH-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_WIDTH-1:0]    rem_q, rem_d;     // partial remainder, always < divisor
  logic [DIVIDEND_WIDTH-2:0]   quo_q, quo_d;     // quotient bits collected so far
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [QUOTIENT_WIDTH-1:0]   quotient_q, quotient_d;
  logic                        overflow_q, overflow_d;
  logic                        dbz_q, dbz_d;

  logic                        accept, go_zero, last_step, release_res;
  logic [RemW-1:0]             r_shift, r_sub, r_next;
  logic                        ge;
  logic [DIVIDEND_WIDTH-1:0]   qu_next;
  logic signed [DIVIDEND_WIDTH:0] q_signed;
  logic [QUOTIENT_WIDTH-1:0]   q_sat;
  logic                        q_ovf;

  assign in_ready    = (state_q == StIdle) && !ap_rst;
  assign out_valid   = (state_q == StDone);
  assign quotient    = quotient_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

  assign accept      = (state_q == StIdle) && in_valid;
  assign go_zero     = accept && (divisor == '0);
  assign last_step   = (state_q == StCalc) && (cnt_q == '0);
  assign release_res = (state_q == StDone) && out_ready;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    r_shift = {rem_q, mag_q[cnt_q]};
    r_sub   = r_shift - {1'b0, dvs_q};
    ge      = (r_shift >= {1'b0, dvs_q});
    r_next  = ge ? r_sub : r_shift;
    qu_next = {quo_q, ge};
  end

  // Apply the dividend sign to the final unsigned quotient and clamp to output range
  always_comb begin
    q_signed = sign_q ? -$signed({1'b0, qu_next}) : $signed({1'b0, qu_next});
    q_sat    = q_signed[QUOTIENT_WIDTH-1:0];
    q_ovf    = 1'b0;
    if (q_signed > QMaxW) begin
      q_sat = QMaxQ;
      q_ovf = 1'b1;
    end else if (q_signed < QMinW) begin
      q_sat = QMinQ;
      q_ovf = 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    overflow_d = overflow_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sign_d = dividend[DIVIDEND_WIDTH-1];
          // -2^30 maps to 2^30, which still fits the unsigned magnitude
          mag_d  = dividend[DIVIDEND_WIDTH-1] ? (~dividend + DIVIDEND_WIDTH'(1)) : dividend;
          dvs_d  = divisor;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = CntW'(DIVIDEND_WIDTH - 1);
          if (go_zero) begin
            state_d    = StDone;
            dbz_d      = 1'b1;
            overflow_d = 1'b0;
            if (dividend == '0) begin
              quotient_d = '0;
            end else if (dividend[DIVIDEND_WIDTH-1]) begin
              quotient_d = QMinQ;
            end else begin
              quotient_d = QMaxQ;
            end
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = r_next[DIVISOR_WIDTH-1:0];
        quo_d = qu_next[DIVIDEND_WIDTH-2:0];
        cnt_d = cnt_q - CntW'(1);
        if (last_step) begin
          state_d    = StDone;
          quotient_d = q_sat;
          overflow_d = q_ovf;
          dbz_d      = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d    = StIdle;
          quotient_d = '0;
          overflow_d = 1'b0;
          dbz_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      overflow_q <= overflow_d;
      dbz_q      <= dbz_d;
    end
  end

`ifdef TC_DIV_REMAINDER_EN
  logic [QUOTIENT_WIDTH-1:0] remainder_q, remainder_d;
  logic [QUOTIENT_WIDTH-1:0] r_ext;

  // Signed remainder follows the dividend sign; cleared on divide-by-zero and release
  always_comb begin
    r_ext       = QUOTIENT_WIDTH'(r_next);
    remainder_d = remainder_q;
    if (go_zero || release_res) begin
      remainder_d = '0;
    end else if (last_step) begin
      remainder_d = sign_q ? (~r_ext + QUOTIENT_WIDTH'(1)) : r_ext;
    end
  end

  // Remainder register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      remainder_q <= '0;
    end else begin
      remainder_q <= remainder_d;
    end
  end

  assign remainder = remainder_q;
`else
  logic unused_rem;
  assign unused_rem = r_next[DIVISOR_WIDTH] ^ release_res;
  assign remainder  = '0;
`endif

endmodule

// File: tb/tb_tc_div_31s_16u_17s.sv
// Self-checking bench for tc_div_31s_16u_17s: directed cases plus randomized
// operands against an arithmetic reference model (integer / and %).
module tb_tc_div_31s_16u_17s;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic [16:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  tc_div_31s_16u_17s dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: truncating division, saturated to 17-bit signed
  function automatic void model(input longint a, input longint b, output longint q,
                                output longint r, output bit ov, output bit dz);
    ov = 1'b0;
    dz = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      r  = 0;
      q  = (a > 0) ? 65535 : ((a < 0) ? -65536 : 0);
    end else begin
      q = a / b;
      r = a % b;
      if (q > 65535) begin
        q  = 65535;
        ov = 1'b1;
      end else if (q < -65536) begin
        q  = -65536;
        ov = 1'b1;
      end
    end
`ifndef TC_DIV_REMAINDER_EN
    r = 0;
`endif
  endfunction

  task automatic run_div(input string tag, input longint a, input longint b, input int hold);
    longint eq, er;
    bit     eo, ez;
    int     lat;
    int     exp_lat;
    model(a, b, eq, er, eo, ez);
    exp_lat  = (b == 0) ? 0 : 31;
    dividend = a[30:0];
    divisor  = b[15:0];
    in_valid = 1'b1;
    check_eq({tag, ":in_ready"}, longint'(in_ready), 1);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    dividend = 31'($urandom);
    divisor  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    check_eq({tag, ":latency"}, longint'(lat), longint'(exp_lat));
    check_eq({tag, ":quotient"}, longint'($signed(quotient)), eq);
    check_eq({tag, ":remainder"}, longint'($signed(remainder)), er);
    check_eq({tag, ":overflow"}, longint'(overflow), longint'(eo));
    check_eq({tag, ":div_by_zero"}, longint'(div_by_zero), longint'(ez));
    check_eq({tag, ":busy"}, longint'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge ap_clk); #1;
      check_eq({tag, ":hold_valid"}, longint'(out_valid), 1);
      check_eq({tag, ":hold_q"}, longint'($signed(quotient)), eq);
      check_eq({tag, ":hold_ready"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ":released"}, longint'(out_valid), 0);
    check_eq({tag, ":idle_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    logic signed [30:0] ds;
    longint a, b;
    bit     seen;
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_eq("rst:in_ready", longint'(in_ready), 0);
    check_eq("rst:out_valid", longint'(out_valid), 0);
    check_eq("rst:quotient", longint'(quotient), 0);
    check_eq("rst:remainder", longint'(remainder), 0);
    check_eq("rst:overflow", longint'(overflow), 0);
    check_eq("rst:div_by_zero", longint'(div_by_zero), 0);
    ap_rst = 1'b0;
    #1;
    check_eq("rst:ready_after", longint'(in_ready), 1);

    run_div("basic", 1000, 7, 0);
    run_div("neg", -1000, 7, 0);
    run_div("roundtrip", -493800000, 40000, 0);
    run_div("sat_pos", 1073741823, 1, 0);
    run_div("sat_neg", -1073741824, 1, 0);
    run_div("dbz_neg", -5, 0, 0);
    run_div("dbz_zero", 0, 0, 0);
    run_div("dbz_pos", 12, 0, 0);
    run_div("hold10", 123456, 321, 10);

    // Reset during CALC discards the operation
    @(posedge ap_clk); #1;
    dividend = 31'd1000;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check_eq("midrst:in_ready_low", longint'(in_ready), 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #1;
    check_eq("midrst:in_ready_high", longint'(in_ready), 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge ap_clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("midrst:no_valid", longint'(seen), 0);
    run_div("midrst_fresh", 1000, 7, 0);

    for (int n = 0; n < 60; n++) begin
      ds = 31'($urandom);
      a  = ds;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = $urandom_range(1, 15);
        2: begin
          a = longint'($urandom_range(0, 200000)) - 100000;
          b = $urandom_range(1, 300);
        end
        default: b = longint'(16'($urandom));
      endcase
      run_div("rand", a, b, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
